// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multicycle control path.
// Holds the FSM state encoding, the ALUOp code sent to alucontroller,
// the datapath mux select encodings and the RV32I major opcodes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_BRANCH = 3'd1,
    ALU_RTYPE  = 3'd2,
    ALU_ITYPE  = 3'd3,
    ALU_PASS_B = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_JALR   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2,
    WB_ALU    = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_REGA  = 2'd2,
    SRCA_ZERO  = 2'd3
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_REGB = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } alu_src_b_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/rv_branch_eval.sv
// Branch resolution from funct3 and the alu is_zero flag.
// Ports:
//   i_funct3   instruction funct3
//   i_is_zero  alu is_zero flag from the BRANCH-op comparison
//   o_take     branch taken
//   o_illegal  funct3 010/011 (no such branch)
module rv_branch_eval (
  input  logic [2:0] i_funct3,
  input  logic       i_is_zero,
  output logic       o_take,
  output logic       o_illegal
);

  // Odd funct3 values are the inverted forms of the even ones.
  assign o_take    = i_funct3[0] ? i_is_zero : !i_is_zero;
  assign o_illegal = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle main control FSM for the RV32I core.
// Sequences PC/IR/regfile/memory/alu one state per cycle, owns the memory
// request handshake, a bus-timeout watchdog and the retired-instruction count.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr                 IR contents (valid from DECODE onward)
//   alu_is_zero           alu zero flag for branch resolution
//   mem_ready             memory accepts/completes the current request
//   mem_req/mem_we/iord   memory request, direction, address select
//   ir_write/mdr_write    IR+OLDPC load, MDR load
//   pc_write/pc_src       PC load and its source
//   reg_write/wb_src      register write enable and writeback source
//   alu_src_a/alu_src_b   alu operand selects
//   alu_op                ALUOp to alucontroller
//   illegal_instr         sticky unsupported-instruction flag
//   bus_error             sticky watchdog-expired flag
//   instret               retired instruction count (wraps)
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 alu_is_zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 mdr_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           wb_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_op,
  output logic                 illegal_instr,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [WAIT_W-1:0]      r_wait;
  logic                   r_illegal;
  logic                   r_bus_err;
  logic [CNT_WIDTH-1:0]   r_instret;

  logic [6:0]             w_opcode;
  logic                   w_take;
  logic                   w_br_illegal;
  logic                   w_timeout;
  logic                   w_set_illegal;
  logic                   w_retire;
  logic                   w_unused;

  assign w_opcode = instr[6:0];
  assign w_unused = &{1'b0, instr[31:15], instr[11:7]};

  rv_branch_eval u_branch_eval (
    .i_funct3  (instr[14:12]),
    .i_is_zero (alu_is_zero),
    .o_take    (w_take),
    .o_illegal (w_br_illegal)
  );

  // Expires on the MEM_TIMEOUT-th stalled request cycle; a same-cycle
  // mem_ready is excluded so the completing memory wins.
  assign w_timeout = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (r_wait == WAIT_LAST);

  always_comb begin
    w_state_next  = r_state;
    w_set_illegal = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_ALU;
    reg_write     = 1'b0;
    wb_src        = WB_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REGB;
    alu_op        = ALU_ADD;

    unique case (r_state)
      S_RST: w_state_next = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          pc_src       = PC_ALU;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
        end
      end

      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        case (w_opcode)
          OPC_OP:       w_state_next = S_EXEC_R;
          OPC_OP_IMM:   w_state_next = S_EXEC_I;
          OPC_LOAD,
          OPC_STORE:    w_state_next = S_MEM_ADDR;
          OPC_BRANCH:   w_state_next = S_BRANCH;
          OPC_JAL:      w_state_next = S_JAL;
          OPC_JALR:     w_state_next = S_JALR;
          OPC_LUI:      w_state_next = S_LUI;
          OPC_AUIPC:    w_state_next = S_AUIPC;
          OPC_MISC_MEM: w_state_next = S_FETCH;
          default: begin
            w_state_next  = S_TRAP;
            w_set_illegal = 1'b1;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a    = SRCA_REGA;
        alu_src_b    = SRCB_REGB;
        alu_op       = ALU_RTYPE;
        w_state_next = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a    = SRCA_REGA;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_ITYPE;
        w_state_next = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write    = 1'b1;
        wb_src       = WB_ALUOUT;
        w_state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a    = SRCA_REGA;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_ADD;
        w_state_next = (w_opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          mdr_write    = 1'b1;
          w_state_next = S_MEM_WB;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
        end
      end

      S_MEM_WB: begin
        reg_write    = 1'b1;
        wb_src       = WB_MDR;
        w_state_next = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          w_state_next = S_FETCH;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
        end
      end

      S_BRANCH: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_REGB;
        alu_op    = ALU_BRANCH;
        if (w_br_illegal) begin
          w_state_next  = S_TRAP;
          w_set_illegal = 1'b1;
        end else begin
          if (w_take) begin
            pc_write = 1'b1;
            pc_src   = PC_ALUOUT;
          end
          w_state_next = S_FETCH;
        end
      end

      S_JAL: begin
        reg_write    = 1'b1;
        wb_src       = WB_PC;
        pc_write     = 1'b1;
        pc_src       = PC_ALUOUT;
        w_state_next = S_FETCH;
      end

      // rd == rs1 is safe: regA was sampled before this edge writes rd.
      S_JALR: begin
        alu_src_a    = SRCA_REGA;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_ADD;
        reg_write    = 1'b1;
        wb_src       = WB_PC;
        pc_write     = 1'b1;
        pc_src       = PC_JALR;
        w_state_next = S_FETCH;
      end

      S_LUI: begin
        alu_src_a    = SRCA_ZERO;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_PASS_B;
        reg_write    = 1'b1;
        wb_src       = WB_ALU;
        w_state_next = S_FETCH;
      end

      S_AUIPC: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_ADD;
        reg_write    = 1'b1;
        wb_src       = WB_ALU;
        w_state_next = S_FETCH;
      end

      S_TRAP: w_state_next = S_TRAP;

      default: w_state_next = S_TRAP;
    endcase
  end

  assign w_retire = (w_state_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_RST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RST;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_next;
      // Any state change clears the wait count, which covers every entry
      // into FETCH/MEM_RD/MEM_WR; it only advances while a request stalls.
      if (w_state_next != r_state) begin
        r_wait <= '0;
      end else if (mem_req && !mem_ready) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_timeout)     r_bus_err <= 1'b1;
      if (w_retire)      r_instret <= r_instret + 1'b1;
    end
  end

  assign illegal_instr = r_illegal;
  assign bus_error     = r_bus_err;
  assign instret       = r_instret;

endmodule
